// File: rtl/branch_ctrl.sv
// branch_ctrl: direct-mapped BTB predictor plus EX-stage branch resolver issuing a registered redirect/flush pulse
module branch_ctrl #(
  parameter int XLEN = 64,
  parameter int BTB_IDX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            cmp_res,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     br_cnt,
  output logic [31:0]     misp_cnt
);
  localparam int N = 2**BTB_IDX;
  localparam int TW = XLEN-BTB_IDX-2;
  logic [N-1:0] btb_valid;
  logic [TW-1:0] btb_tag [N];
  logic [XLEN-1:0] btb_target [N];
  logic [1:0] btb_ctr [N];
  logic [BTB_IDX-1:0] if_idx, ex_idx;
  logic [TW-1:0] if_tag, ex_tag;
  logic if_hit, ex_hit, resolve, actual_taken, mispredict;
  logic [XLEN-1:0] actual_pc;
  logic unused_ok;
  assign unused_ok = &{1'b0, if_pc[1:0]};
  assign if_idx = if_pc[BTB_IDX+1:2];
  assign if_tag = if_pc[XLEN-1:BTB_IDX+2];
  assign ex_idx = ex_pc[BTB_IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:BTB_IDX+2];
  assign if_hit = btb_valid[if_idx] && btb_tag[if_idx] == if_tag;
  assign ex_hit = btb_valid[ex_idx] && btb_tag[ex_idx] == ex_tag;
  assign if_pred_taken = !rst && if_hit && btb_ctr[if_idx][1];
  assign if_pred_target = if_pred_taken ? btb_target[if_idx] : '0;
  assign resolve = ex_valid && (ex_is_branch || ex_is_jump) && !ex_stall && !redirect;
  assign actual_taken = ex_is_jump || (ex_is_branch && cmp_res);
  assign actual_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);
  assign mispredict = (ex_pred_taken != actual_taken) || (actual_taken && ex_pred_target != ex_target);
  assign flush = redirect;
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      redirect <= 1'b0;
      redirect_pc <= '0;
      br_cnt <= '0;
      misp_cnt <= '0;
    end else begin
      redirect <= resolve && mispredict;
      if (resolve && mispredict) redirect_pc <= actual_pc;
      br_cnt <= br_cnt + 32'(resolve);
      misp_cnt <= misp_cnt + 32'(resolve && mispredict);
      if (resolve && ex_is_jump) begin
        btb_valid[ex_idx] <= 1'b1;
        btb_tag[ex_idx] <= ex_tag;
        btb_target[ex_idx] <= ex_target;
        btb_ctr[ex_idx] <= 2'b11;
      end else if (resolve && ex_hit) begin
        btb_ctr[ex_idx] <= actual_taken ? (btb_ctr[ex_idx] == 2'b11 ? 2'b11 : btb_ctr[ex_idx] + 2'd1)
                                        : (btb_ctr[ex_idx] == 2'b00 ? 2'b00 : btb_ctr[ex_idx] - 2'd1);
        if (actual_taken) btb_target[ex_idx] <= ex_target;
      end else if (resolve && actual_taken) begin
        btb_valid[ex_idx] <= 1'b1;
        btb_tag[ex_idx] <= ex_tag;
        btb_target[ex_idx] <= ex_target;
        btb_ctr[ex_idx] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed and randomized checks of branch_ctrl against a behavioural BTB model
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] if_pc, if_pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
  logic if_pred_taken, ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_pred_taken, cmp_res;
  logic redirect, flush;
  logic [31:0] br_cnt, misp_cnt, b0, m0;
  int checks = 0;
  int errors = 0;
  bit m_v [16];
  logic [63:0] m_pc [16];
  logic [63:0] m_tgt [16];
  int m_ctr [16];
  bit m_red;
  logic [63:0] m_rpc;
  int unsigned m_br, m_misp;
  logic [64:0] p;

  branch_ctrl #(.XLEN(64), .BTB_IDX(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .cmp_res(cmp_res), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .br_cnt(br_cnt), .misp_cnt(misp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mpred(input logic [63:0] pc);
    int i;
    i = int'((pc >> 2) % 16);
    if (!rst && m_v[i] && (m_pc[i] >> 6) == (pc >> 6) && m_ctr[i] >= 2) return {1'b1, m_tgt[i]};
    return 65'd0;
  endfunction

  task automatic tick();
    logic [64:0] pr;
    logic [63:0] apc;
    bit res, at, mp, hit;
    int i;
    #3;
    pr = mpred(if_pc);
    chk("pred_taken", {63'd0, if_pred_taken}, {63'd0, pr[64]});
    chk("pred_target", if_pred_target, pr[63:0]);
    res = ex_valid && (ex_is_branch || ex_is_jump) && !ex_stall && !m_red;
    at = ex_is_jump || (ex_is_branch && cmp_res);
    apc = at ? ex_target : ex_pc + 64'd4;
    mp = (ex_pred_taken != at) || (at && ex_pred_target != ex_target);
    i = int'((ex_pc >> 2) % 16);
    hit = m_v[i] && (m_pc[i] >> 6) == (ex_pc >> 6);
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (m_v[k]) m_v[k] = 1'b0;
      m_red = 1'b0;
      m_rpc = '0;
      m_br = 0;
      m_misp = 0;
    end else begin
      m_red = res && mp;
      if (m_red) m_rpc = apc;
      if (res) m_br++;
      if (res && mp) m_misp++;
      if (res && ex_is_jump) begin
        m_v[i] = 1'b1; m_pc[i] = ex_pc; m_tgt[i] = ex_target; m_ctr[i] = 3;
      end else if (res && hit) begin
        m_ctr[i] += at ? 1 : -1;
        if (m_ctr[i] > 3) m_ctr[i] = 3;
        if (m_ctr[i] < 0) m_ctr[i] = 0;
        if (at) m_tgt[i] = ex_target;
      end else if (res && at) begin
        m_v[i] = 1'b1; m_pc[i] = ex_pc; m_tgt[i] = ex_target; m_ctr[i] = 2;
      end
    end
    chk("redirect", {63'd0, redirect}, {63'd0, m_red});
    chk("flush", {63'd0, flush}, {63'd0, m_red});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("br_cnt", {32'd0, br_cnt}, {32'd0, m_br});
    chk("misp_cnt", {32'd0, misp_cnt}, {32'd0, m_misp});
  endtask

  task automatic set_ex(input bit v, input bit br, input bit j, input logic [63:0] pc,
                        input logic [63:0] tg, input bit pt, input logic [63:0] ptg,
                        input bit c, input bit st);
    ex_valid = v; ex_is_branch = br; ex_is_jump = j; ex_pc = pc; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg; cmp_res = c; ex_stall = st;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 64'h0;
    idle();
    m_red = 1'b0; m_rpc = '0; m_br = 0; m_misp = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_br_cnt", {32'd0, br_cnt}, 64'd0);
    chk("reset_redirect", {63'd0, redirect}, 64'd0);
    if_pc = 64'h100;
    tick();
    chk("pred_cold", {63'd0, if_pred_taken}, 64'd0);
    set_ex(1, 1, 0, 64'h100, 64'h180, 0, 64'h0, 1, 0);
    tick();
    idle();
    chk("first_misp_pc", redirect_pc, 64'h180);
    chk("first_misp_cnt", {32'd0, misp_cnt}, 64'd1);
    #1;
    chk("alloc_taken", {63'd0, if_pred_taken}, 64'd1);
    chk("alloc_target", if_pred_target, 64'h180);
    tick();
    set_ex(1, 1, 0, 64'h100, 64'h180, 1, 64'h180, 0, 0);
    tick();
    chk("nt_redirect_pc", redirect_pc, 64'h104);
    idle();
    tick();
    set_ex(1, 1, 0, 64'h100, 64'h180, 0, 64'h0, 0, 0);
    tick();
    idle();
    #1;
    chk("ctr_zero", {63'd0, if_pred_taken}, 64'd0);
    repeat (5) begin
      p = mpred(64'h100);
      set_ex(1, 1, 0, 64'h100, 64'h180, p[64], p[63:0], 1, 0);
      tick();
      idle();
      tick();
    end
    set_ex(1, 1, 0, 64'h100, 64'h180, 1, 64'h180, 0, 0);
    tick();
    idle();
    tick();
    #1;
    chk("ctr_saturated", {63'd0, if_pred_taken}, 64'd1);
    b0 = br_cnt;
    set_ex(1, 1, 0, 64'h108, 64'h300, 0, 64'h0, 1, 1);
    repeat (3) tick();
    ex_stall = 1'b0;
    tick();
    idle();
    tick();
    chk("stall_once", {32'd0, br_cnt}, {32'd0, b0 + 32'd1});
    set_ex(1, 1, 0, 64'h140, 64'h1c0, 0, 64'h0, 1, 0);
    tick();
    b0 = br_cnt;
    set_ex(1, 1, 0, 64'h300, 64'h380, 0, 64'h0, 1, 0);
    tick();
    idle();
    chk("shadow_br_cnt", {32'd0, br_cnt}, {32'd0, b0});
    chk("shadow_redirect", {63'd0, redirect}, 64'd0);
    if_pc = 64'h300;
    #1;
    chk("shadow_no_alloc", {63'd0, if_pred_taken}, 64'd0);
    b0 = br_cnt;
    m0 = misp_cnt;
    set_ex(1, 0, 1, 64'h200, 64'h400, 1, 64'h400, 0, 0);
    tick();
    idle();
    chk("jal_no_redirect", {63'd0, redirect}, 64'd0);
    chk("jal_br_cnt", {32'd0, br_cnt}, {32'd0, b0 + 32'd1});
    chk("jal_misp_cnt", {32'd0, misp_cnt}, {32'd0, m0});
    if_pc = 64'h200;
    #1;
    chk("jal_pred", {63'd0, if_pred_taken}, 64'd1);
    chk("jal_target", if_pred_target, 64'h400);
    set_ex(1, 1, 0, 64'h180, 64'h500, 0, 64'h0, 1, 0);
    tick();
    idle();
    chk("pending_redirect", {63'd0, redirect}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drops_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_clears_cnt", {32'd0, br_cnt}, 64'd0);
    repeat (800) begin
      rst = ($urandom_range(0, 199) == 0);
      if_pc = 64'h100 + 64'(4 * $urandom_range(0, 47));
      ex_valid = $urandom_range(0, 3) != 0;
      ex_is_branch = $urandom_range(0, 1) == 1;
      ex_is_jump = $urandom_range(0, 4) == 0;
      ex_pc = 64'h100 + 64'(4 * $urandom_range(0, 47));
      ex_target = 64'h1000 + 64'(4 * $urandom_range(0, 7));
      cmp_res = $urandom_range(0, 1) == 1;
      ex_stall = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 3) != 0) begin
        p = mpred(ex_pc);
        ex_pred_taken = p[64];
        ex_pred_target = p[63:0];
      end else begin
        ex_pred_taken = $urandom_range(0, 1) == 1;
        ex_pred_target = 64'h1000 + 64'(4 * $urandom_range(0, 7));
      end
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
